// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - state encoding and shift-register select codes for shift_sequencer
package shift_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  localparam logic [2:0] HOLD = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] SHR  = 3'd2;
  localparam logic [2:0] SHL  = 3'd3;
  localparam logic [2:0] ROR  = 3'd4;
  localparam logic [2:0] ROL  = 3'd5;
  localparam logic [2:0] ASR  = 3'd6;
  localparam logic [2:0] ASL  = 3'd7;

  // Only codes that actually move bits are legal command ops.
  function automatic logic op_is_shift(input logic [2:0] op);
    return (op >= SHR);
  endfunction

endpackage

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - sequences load/shift/read-back of an external shift register
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [2:0]            i_cmd_op,
  input  logic [AMT_WIDTH-1:0]  i_cmd_amt,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  input  logic                  i_cmd_fill,
  input  logic                  i_abort,
  output logic [2:0]            o_sr_s,
  output logic [DATA_WIDTH-1:0] o_sr_d,
  output logic                  o_sr_rin,
  output logic                  o_sr_lin,
  output logic                  o_sr_rst,
  input  logic [DATA_WIDTH-1:0] i_sr_q,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [DATA_WIDTH-1:0] o_res_data,
  output logic                  o_res_err
);

  localparam logic [AMT_WIDTH-1:0] AMT_MAX = AMT_WIDTH'(DATA_WIDTH);
  localparam logic [AMT_WIDTH-1:0] AMT_ONE = AMT_WIDTH'(1);

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_op;
  logic [AMT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_fill;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_illegal;
  logic [AMT_WIDTH-1:0]  w_eff_amt;

  assign w_accept  = (r_state == ST_IDLE) && i_cmd_valid;
  assign w_illegal = !op_is_shift(i_cmd_op);
  // Clamp rather than wrap: shifting past the full width must saturate.
  assign w_eff_amt = (i_cmd_amt > AMT_MAX) ? AMT_MAX : i_cmd_amt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_op   <= HOLD;
      r_cnt  <= '0;
      r_data <= '0;
      r_fill <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= i_cmd_op;
        r_cnt  <= w_eff_amt;
        r_data <= i_cmd_data;
        r_fill <= i_cmd_fill;
        r_err  <= w_illegal;
      end else if ((r_state == ST_SHIFT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - AMT_ONE;
      end else if (r_state == ST_CLEAR) begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    o_cmd_ready = 1'b0;
    o_sr_s      = HOLD;
    o_sr_d      = '0;
    o_sr_rin    = 1'b0;
    o_sr_lin    = 1'b0;
    o_sr_rst    = 1'b0;
    o_res_valid = 1'b0;
    o_res_data  = '0;
    o_res_err   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_next = w_illegal ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        o_sr_s = LOAD;
        o_sr_d = r_data;
        if (i_abort) begin
          w_next = ST_CLEAR;
        end else if (r_cnt != '0) begin
          w_next = ST_SHIFT;
        end else begin
          w_next = ST_DONE;
        end
      end
      ST_SHIFT: begin
        o_sr_s   = r_op;
        o_sr_rin = r_fill;
        o_sr_lin = r_fill;
        if (i_abort) begin
          w_next = ST_CLEAR;
        end else if (r_cnt == AMT_ONE) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Abort wins over a same-cycle result handshake, so valid is withdrawn.
        o_res_valid = !i_abort;
        o_res_data  = r_err ? r_data : i_sr_q;
        o_res_err   = r_err;
        if (i_abort) begin
          w_next = ST_CLEAR;
        end else if (i_res_ready) begin
          w_next = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        o_sr_rst = 1'b1;
        w_next   = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed bench pairing shift_sequencer with a 16-bit shift register
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_amt;
  logic [DW-1:0] cmd_data;
  logic          cmd_fill;
  logic          abort;
  logic [2:0]    sr_s;
  logic [DW-1:0] sr_d;
  logic          sr_rin;
  logic          sr_lin;
  logic          sr_rst;
  logic [DW-1:0] sr_q;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_err;

  int n_cmp;
  int n_err;

  shift_sequencer #(.DATA_WIDTH(DW), .AMT_WIDTH(AW)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_amt   (cmd_amt),
    .i_cmd_data  (cmd_data),
    .i_cmd_fill  (cmd_fill),
    .i_abort     (abort),
    .o_sr_s      (sr_s),
    .o_sr_d      (sr_d),
    .o_sr_rin    (sr_rin),
    .o_sr_lin    (sr_lin),
    .o_sr_rst    (sr_rst),
    .i_sr_q      (sr_q),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data),
    .o_res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 16-bit universal shift register; not tied to rstn.
  always_ff @(posedge clk) begin
    if (sr_rst) sr_q <= '0;
    else begin
      case (sr_s)
        LOAD:    sr_q <= sr_d;
        SHR:     sr_q <= {sr_rin, sr_q[DW-1:1]};
        SHL:     sr_q <= {sr_q[DW-2:0], sr_lin};
        ROR:     sr_q <= {sr_q[0], sr_q[DW-1:1]};
        ROL:     sr_q <= {sr_q[DW-2:0], sr_q[DW-1]};
        ASR:     sr_q <= {sr_q[DW-1], sr_q[DW-1:1]};
        ASL:     sr_q <= {sr_q[DW-2:0], 1'b0};
        default: sr_q <= sr_q;
      endcase
    end
  end

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [DW-1:0] data;
    logic          fill;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    int            exp_lat;
    int            exp_shifts;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic offer(input logic [2:0] op, input logic [AW-1:0] amt,
                       input logic [DW-1:0] data, input logic fill);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = data;
    cmd_fill  = fill;
  endtask

  task automatic drop();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_amt   = '0;
    cmd_data  = '0;
    cmd_fill  = 1'b0;
  endtask

  // Called at the first negedge after the accept edge; lat counts cycles from accept.
  task automatic wait_valid(output int lat, output int shifts, output int loads);
    lat = 1;
    shifts = 0;
    loads = 0;
    while (!res_valid && lat < 60) begin
      if (sr_s == LOAD) loads++;
      else if (sr_s != HOLD) shifts++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input int idx);
    int lat, shifts, loads;
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    chk($sformatf("v%0d_ready_idle", idx), cmd_ready, 1);
    offer(v.op, v.amt, v.data, v.fill);
    @(negedge clk);
    drop();
    chk($sformatf("v%0d_ready_busy", idx), cmd_ready, 0);
    wait_valid(lat, shifts, loads);
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_data", idx), res_data, v.exp_data);
    chk($sformatf("v%0d_err", idx), res_err, v.exp_err);
    chk($sformatf("v%0d_shifts", idx), shifts, v.exp_shifts);
    chk($sformatf("v%0d_loads", idx), loads, v.exp_err ? 0 : 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk($sformatf("v%0d_ready_after", idx), cmd_ready, 1);
  endtask

  initial begin
    int lat, shifts, loads, rst_cnt, vld_cnt;
    bit stable;

    n_cmp = 0;
    n_err = 0;
    vecs[0]  = '{3'd4, 5'd1,  16'h8001, 1'b0, 16'hC000, 1'b0, 3,  1};
    vecs[1]  = '{3'd6, 5'd4,  16'h8000, 1'b0, 16'hF800, 1'b0, 6,  4};
    vecs[2]  = '{3'd3, 5'd20, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 18, 16};
    vecs[3]  = '{3'd1, 5'd0,  16'h1234, 1'b0, 16'h1234, 1'b1, 1,  0};
    vecs[4]  = '{3'd0, 5'd5,  16'hABCD, 1'b1, 16'hABCD, 1'b1, 1,  0};
    vecs[5]  = '{3'd2, 5'd0,  16'h00F0, 1'b0, 16'h00F0, 1'b0, 2,  0};
    vecs[6]  = '{3'd5, 5'd17, 16'h0001, 1'b0, 16'h0001, 1'b0, 18, 16};
    vecs[7]  = '{3'd2, 5'd31, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 18, 16};
    vecs[8]  = '{3'd7, 5'd3,  16'h00F0, 1'b0, 16'h0780, 1'b0, 5,  3};
    vecs[9]  = '{3'd2, 5'd2,  16'hF000, 1'b1, 16'hFC00, 1'b0, 4,  2};
    vecs[10] = '{3'd3, 5'd4,  16'h0001, 1'b0, 16'h0010, 1'b0, 6,  4};

    rstn = 1'b0;
    abort = 1'b0;
    res_ready = 1'b0;
    drop();
    #2;
    chk("rst_sr_s", sr_s, 0);
    chk("rst_sr_rst", sr_rst, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_res_data", res_data, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Abort during the third shift cycle of an 8-cycle command.
    @(negedge clk);
    offer(SHR, 5'd8, 16'h00FF, 1'b0);
    @(negedge clk);
    drop();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("ab_third_shift", sr_s, SHR);
    abort = 1'b1;
    rst_cnt = 0;
    vld_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      abort = 1'b0;
      rst_cnt += int'(sr_rst);
      vld_cnt += int'(res_valid);
      if (k == 0) chk("ab_clear_ready", cmd_ready, 0);
      if (k == 1) begin
        chk("ab_ready_2later", cmd_ready, 1);
        chk("ab_sr_cleared", sr_q, 0);
      end
    end
    chk("ab_rst_pulses", rst_cnt, 1);
    chk("ab_no_result", vld_cnt, 0);

    // Result held across five cycles of back-pressure, then aborted in DONE.
    @(negedge clk);
    offer(ROR, 5'd1, 16'h8001, 1'b0);
    @(negedge clk);
    drop();
    wait_valid(lat, shifts, loads);
    chk("hold_latency", lat, 3);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!res_valid || res_data != 16'hC000 || sr_s != HOLD) stable = 1'b0;
      @(negedge clk);
    end
    chk("hold_stable", stable, 1);
    chk("hold_data_after", res_data, 16'hC000);
    abort = 1'b1;
    res_ready = 1'b1;
    #1;
    chk("done_abort_valid", res_valid, 0);
    @(negedge clk);
    abort = 1'b0;
    res_ready = 1'b0;
    chk("done_abort_clear", sr_rst, 1);
    @(negedge clk);
    chk("done_abort_idle", cmd_ready, 1);

    // Abort raised together with an accept in IDLE is ignored.
    offer(SHL, 5'd2, 16'h0001, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    drop();
    abort = 1'b0;
    chk("idle_abort_load", sr_s, LOAD);
    chk("idle_abort_norst", sr_rst, 0);
    wait_valid(lat, shifts, loads);
    chk("idle_abort_lat", lat, 4);
    chk("idle_abort_data", res_data, 16'h0007);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    // Asynchronous reset in the middle of shifting.
    offer(ROR, 5'd8, 16'h0F0F, 1'b0);
    @(negedge clk);
    drop();
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_shifting", sr_s, ROR);
    rstn = 1'b0;
    #1;
    chk("mid_rst_sr_s", sr_s, 0);
    chk("mid_rst_sr_rst", sr_rst, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_data", res_data, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_sr_kept", sr_q, 16'h8787);
    rstn = 1'b1;
    vld_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vld_cnt += int'(res_valid);
    end
    chk("mid_rst_no_result", vld_cnt, 0);

    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
